// File: rtl/mux_arb_n.sv
// mux_arb_n: N-input valid/ready selector (fixed select or round-robin) feeding one registered output stage
module mux_arb_n #(
    parameter int WIDTH = 16,
    parameter int N = 4,
    parameter int SELW = $clog2(N),
    parameter int MODE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_src
);
    logic [SELW-1:0] ptr, g;
    logic hit, load;
    assign load = !out_valid || out_ready;
    always_comb begin
        g = '0;
        hit = 1'b0;
        if (MODE == 0) begin
            if (int'(sel) < N && in_valid[sel]) begin
                hit = 1'b1;
                g = sel;
            end
        end else begin
            // scan from the far end so the channel nearest ptr wins
            for (int k = N - 1; k >= 0; k--)
                if (in_valid[(int'(ptr) + k) % N]) begin
                    hit = 1'b1;
                    g = SELW'((int'(ptr) + k) % N);
                end
        end
    end
    assign in_ready = (hit && load) ? N'(1) << g : '0;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out_valid <= 1'b0;
            out_data <= '0;
            out_src <= '0;
            ptr <= '0;
        end else if (load) begin
            out_valid <= hit;
            if (hit) begin
                out_data <= in_data[int'(g)*WIDTH +: WIDTH];
                out_src <= g;
                if (MODE == 1) ptr <= SELW'((int'(g) + 1) % N);
            end
        end
endmodule

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
- Parametrised N-input, WIDTH-bit selector with a valid/ready handshake on every input and one registered output stage.
- Operates in one of two modes, fixed at build time: externally selected (`sel` port) or round-robin arbitrated.
- Used where several producers (writeback sources, memory/ALU results) share one downstream consumer that can stall.
- Replaces ad-hoc combinational 4:1 result selection wherever back-pressure or fairness is needed.

Parameters:
- WIDTH, 16: data width in bits.
- N, 4: number of input channels; any value ≥ 2, not limited to powers of two.
- SELW, $clog2(N): width of `sel` and `out_src`. Derived; never overridden.
- MODE, 0: 0 = fixed select via `sel`; 1 = round-robin arbitration, `sel` ignored.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational.
- sel  input  SELW  channel select, used only when MODE=0.
- out_data  output  WIDTH  registered data.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.
- out_src  output  SELW  registered index of the channel that supplied `out_data`.

Behaviour:
- Reset (asynchronous, any time): `out_valid`=0, `out_data`=0, `out_src`=0, round-robin pointer `ptr`=0. Any in-flight word is dropped.
- `load` = `!out_valid || out_ready`. The output register can accept a new word this cycle when `load` is true.
- Grant, MODE=0:
  - Grant channel `sel` if `in_valid[sel]`, otherwise no grant.
  - A `sel` value ≥ N produces no grant.
- Grant, MODE=1:
  - Search channels `ptr`, `ptr+1`, … wrapping modulo N.
  - Grant the first channel with `in_valid` set; none if all are low.
- Ready: `in_ready[g]` = `load` for the granted channel `g`; all other bits of `in_ready` are 0. At most one bit is ever set.
- Transfer on channel g: `in_valid[g] && in_ready[g]` at a rising edge. The output register captures `out_data` = channel g data, `out_src` = g, `out_valid` = 1.
- Latency: 1 cycle from input transfer to `out_valid`. Throughput: 1 word per cycle while `out_ready` is held high.
- Output drains with no new transfer (`out_ready`=1 and no grant): `out_valid` goes to 0; `out_data` and `out_src` hold their last values.
- Stall (`out_valid`=1, `out_ready`=0): `out_data`, `out_src` and `out_valid` hold stable; all `in_ready` bits are 0.
- Pointer update (MODE=1 only): after each transfer, `ptr` = (g+1) mod N, wrapping correctly for non-power-of-two N. `ptr` is unchanged when no transfer occurs. MODE=0 keeps `ptr` at 0.
- Simultaneous drain and fill (`out_valid`=1, `out_ready`=1, grant present): the new word replaces the old one in the same edge, with no bubble.
- Inputs must not drop `in_valid` before their transfer completes. The block does not check this.
- Fairness (MODE=1): with all channels continuously valid and `out_ready`=1, grants cycle 0,1,…,N-1,0,….

Test Plan:
- Reset and idle: assert `rst` mid-stream with `out_valid`=1 → `out_valid`=0, `out_data`=0, `out_src`=0 immediately, without waiting for a clock edge. After release, the first grant in MODE=1 goes to channel 0.
- Fixed select, MODE=0, N=4: `sel`=2, `in_data` ch2=16'hBEEF, `in_valid`=4'b1111, `out_ready`=1 → one cycle later `out_data`=16'hBEEF, `out_src`=2. `in_ready`=4'b0100 throughout.
- Round-robin, MODE=1, N=3: all valid with data 16'h0011/16'h0022/16'h0033, `out_ready`=1 for 6 cycles → `out_src` sequence 0,1,2,0,1,2. No bubbles.
- Back-pressure: `out_valid`=1 with 16'h1234, `out_ready`=0 for 3 cycles → `out_data` stays 16'h1234. `in_ready`=0 and `ptr` is unchanged.
- Sparse requests: MODE=1, N=4, `ptr`=3, only ch1 valid → grant ch1, then `ptr`=2. Next, ch0 and ch3 valid → ch3 granted first, then ch0.
- Drain with nothing pending: `out_valid`=1, `out_ready`=1, `in_valid`=0 → `out_valid`=0 next cycle; `out_data` and `out_src` retain their values.
